// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM stage register: main + skid entry behind a valid/ready handshake,
// synchronous flush to a bubble, and a saturating stall counter.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no payload held, out_data is a bubble
// ST_ONE   | payload in main register only
// ST_FULL  | main and skid both held, in_ready low
module ex_mem_pipe_reg #(
  parameter int                CNT_W     = 16,
  parameter int                DATA_W    = 74,
  parameter logic [DATA_W-1:0] CTRL_MASK = {4'hF, {(DATA_W-4){1'b0}}}
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // State register: also holds the payload flops and the counter.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (!push && pop) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Any move into EMPTY strips the control bits so the bubble is harmless.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = main_q & ~CTRL_MASK;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) main_d = in_data;
        ST_ONE: begin
          if (push && pop) main_d = in_data;
          else if (push)   skid_d = in_data;
          else if (pop)    main_d = main_q & ~CTRL_MASK;
        end
        ST_FULL:  if (pop) main_d = skid_q;
        default:  main_d = main_q & ~CTRL_MASK;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Handshake outputs come from flops fed by the next state only.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush, and a saturating stall counter. It sits between the execute and memory stages. It replaces a fixed-width, always-loading stage register, so a memory-side stall no longer corrupts or drops an in-flight instruction. A flush turns the stage into a bubble by clearing its control bits.

## Interface
- DATA_W, 74, width of the packed stage payload (zero, ALU result, store data, dest reg, control bits).
- CTRL_MASK, DATA_W'b bits [73:70] set, payload bits cleared whenever the stage becomes a bubble (RegWrite, MemRead, MemWrite, MemtoReg).
- CNT_W, 16, width of the stall counter.
- clock  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  execute stage presents a payload.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  execute-stage payload.
- flush  in  1  discard all held and incoming payloads this cycle.
- out_valid  out  1  memory stage payload valid; registered.
- out_ready  in  1  memory stage consumes out_data this cycle.
- out_data  out  DATA_W  held payload (main register).
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

## Operation
- Storage: a main register (drives out_data) and a skid register. The state is EMPTY, ONE or FULL, and occupancy encodes it as 0/1/2.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- EMPTY: push → ONE, main<=in_data.
- ONE:
  - Push and pop → ONE, main<=in_data.
  - Push only → FULL, skid<=in_data.
  - Pop only → EMPTY.
  - Neither → hold.
- FULL: in_ready=0, so no push is possible. Pop → ONE, main<=skid. No pop → hold.
- Bubble rule: on every transition into EMPTY, main<=main & ~CTRL_MASK. While empty, out_data therefore carries no write or memory enables.
- Flush (priority below reset, above everything else):
  - Next state is EMPTY and main<=main & ~CTRL_MASK.
  - in_data in the same cycle is dropped, even if in_valid=1.
  - A pop in the same cycle still counts as consumed by the downstream stage.
- Stall counter: increments by 1 each cycle with out_valid=1 and out_ready=0. It holds at all-ones and never wraps. Only reset clears it.
- Outputs:
  - in_ready = (state != FULL), from a flop.
  - out_valid = (state != EMPTY), from a flop.
  - Neither output has a combinational path from in_valid, out_ready or flush.

## Timing
- Reset (rst=0 at a rising edge) sets:
  - state=EMPTY, main=0, skid=0, stall_cnt=0;
  - out_valid=0, out_data=0, occupancy=0;
  - in_ready=1 from the first edge after reset releases.
- Reset asserted mid-operation discards both entries at that edge. No partial update occurs.
- Latency: a payload pushed at edge N appears on out_data with out_valid=1 after edge N. This is 1 cycle.
- Throughput: 1 payload per cycle when out_ready is held at 1. The skid register stays unused.
- Backpressure: with out_ready=0, the stage accepts at most 2 payloads. in_ready drops after the edge that fills the skid register.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- Simultaneous flush and pop in FULL: both entries are dropped and the next state is EMPTY.
- stall_cnt updates on the same edge as the state and reflects cycles up to and including the previous one.

## Test plan
- Reset check: hold rst=0 for 3 cycles with in_valid=1 and in_data=all-ones. Required after reset: out_valid=0, out_data=0, occupancy=0, stall_cnt=0. After release, in_ready=1.
- Streaming: with out_ready=1, push 0x1, 0x2, 0x3 on consecutive cycles. out_data must show 0x1/0x2/0x3 one cycle later, in order, with out_valid=1 throughout. occupancy never exceeds 1.
- Backpressure: with out_ready=0, push A then B. The cycle after B, in_ready=0 and occupancy=2. A third payload C held on in_valid is not accepted. Then raise out_ready: output order must be A, B, C, and stall_cnt increments once per stalled cycle.
- Flush: with the stage FULL, assert flush together with in_valid=1 and D whose bits [73:70]=4'hF. Next cycle: out_valid=0, occupancy=0, in_ready=1, out_data[73:70]=0. D never appears at the output.
- Counter saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. stall_cnt must reach 15 and stay at 15.
- Mid-operation reset: with the stage FULL and stall_cnt=7, pull rst low for one edge. Next cycle: all outputs at their reset values and no stale payload emitted afterwards.
